bcd_switch_reader: RTL and testbench
====================================

# bcd_switch_reader

Input-side counterpart of the board's two-digit BCD pin output. It samples two 4-bit BCD digit inputs from external thumbwheel/DIP switches on board pins and synchronizes and debounces them. It converts each stable reading to a 7-bit binary value of 0–99 and hands it to the multicycle core's I/O port over a valid/ready handshake, with one-deep pending buffering.

## Interface
- DEBOUNCE_CYCLES, 16000, consecutive identical synchronized samples required before a reading is committed (1 ms at 16 MHz); legal range ≥2.
- CLK  input  1  system clock, 16 MHz; all state updates on the rising edge.
- RST_N  input  1  asynchronous, active-low reset; one clock domain only.
- ones_pin  input  4  raw asynchronous ones-digit pins, BCD, bit 0 = LSB.
- tens_pin  input  4  raw asynchronous tens-digit pins, BCD.
- value  output  7  binary reading, tens*10 + ones.
- valid  output  1  value holds an undelivered reading.
- ready  input  1  consumer accepts value when valid && ready at a rising edge.
- bcd_error  output  1  level; last committed reading had a nibble > 9.
- overrun  output  1  one-cycle pulse; pending reading overwritten before delivery.

## Operation
- Synchronizer: two flops on the 8-bit bus {tens_pin, ones_pin}; reset 8'h00.
- Debouncer: candidate register (reset 8'hFF) and counter (reset 0).
  - If the sync output differs from candidate: candidate <= sync output, counter <= 0.
  - Otherwise the counter increments, saturating at DEBOUNCE_CYCLES-1.
- Commit: when counter == DEBOUNCE_CYCLES-1 and candidate != committed (reset 8'hFF):
  - committed <= candidate, and a one-cycle commit event is registered.
  - Because committed resets to 8'hFF, the first stable reading after reset is always committed.
- Validation on commit:
  - Both nibbles ≤ 9: the reading converts to tens*10 + ones = (t<<3)+(t<<1)+o, 7 bits, no overflow possible (max 99). bcd_error <= 0. The reading is offered to the output FSM.
  - Otherwise: bcd_error <= 1, nothing is offered, and value/valid/pending are untouched.
- Output FSM, states EMPTY, FULL, FULL_PEND (pending register, 7 bits):
  - EMPTY + offer: value <= new, go to FULL.
  - FULL + ready, no offer: go to EMPTY.
  - FULL + ready + offer: value <= new, stay FULL; valid stays high.
  - FULL + offer, no ready: pending <= new, go to FULL_PEND.
  - FULL_PEND + ready, no offer: value <= pending, go to FULL.
  - FULL_PEND + ready + offer: value <= pending, pending <= new, stay FULL_PEND.
  - FULL_PEND + offer, no ready: pending <= new, overrun = 1 for one cycle.
  - value never changes while valid && !ready.
- valid = (state != EMPTY), registered.
- Reset mid-operation: all state returns to reset values immediately; any pending or undelivered reading is discarded, and debounce restarts.

## Timing
- Reset values: value 0, valid 0, bcd_error 0, overrun 0; state EMPTY.
- Latency, clean edge with output EMPTY: pins change before edge 0; valid rises after edge DEBOUNCE_CYCLES+4, with value valid the same cycle.
- A bounce resets the counter, so latency is measured from the last pin transition.
- Handshake: transfer at the edge where valid && ready. valid drops the following cycle only if no reading remains, giving throughput of one reading per cycle when pending.
- bcd_error updates on the cycle after the commit event, the same edge value/valid would update.
- A reading equal to committed is never re-delivered. A valid reading following an invalid one is delivered even if it equals the last delivered value.

## Test plan
- Reset, pins 8'h42 steady, DEBOUNCE_CYCLES=4, ready=0: valid rises after edge 8 with value=42; bcd_error=0; valid holds and value stays stable.
- Pins toggle 8'h17↔8'h18 every 2 cycles for 20 cycles, then hold 8'h18: no commit during bouncing; value=18 delivered DEBOUNCE_CYCLES+4 cycles after the last toggle.
- ready=0, stable readings 8'h05, 8'h06, 8'h07 in sequence: value=5; pending 6 is overwritten by 7 with a single overrun pulse; asserting ready then delivers 5, then 7, valid high for both, then valid low.
- Pins 8'h3A stable: bcd_error=1, valid/value unchanged. Then 8'h99: bcd_error=0, value=99.
- Same reading 8'h42 re-presented after a transient shorter than DEBOUNCE_CYCLES: no new valid. RST_N pulsed low mid-debounce with valid=1: outputs return to reset values within the reset cycle, and 42 is re-delivered after the full latency.
- ready held high, reading changes 8'h00→8'h01 while a transfer occurs the same cycle: FULL+ready+offer path, valid stays high, value=1 on the next cycle.

Source files
------------

// File: rtl/bcd_switch_reader_if.sv
// rtl/bcd_switch_reader_if.sv - valid/ready reading port between the switch reader and the core
interface bcd_switch_reader_if;
  logic [6:0] value;
  logic       valid;
  logic       ready;

  modport master (output value, output valid, input ready);
  modport slave  (input value, input valid, output ready);
endinterface

// File: rtl/bcd_switch_reader.sv
// rtl/bcd_switch_reader.sv - two-digit BCD switch sampler: sync, debounce, convert, one-deep buffered handshake
module bcd_switch_reader #(
  parameter int DEBOUNCE_CYCLES = 16000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [3:0]               ones_pin,
  input  logic [3:0]               tens_pin,
  output logic                     bcd_error,
  output logic                     overrun,
  bcd_switch_reader_if.master      bus
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {EMPTY, FULL, FULL_PEND} state_t;

  logic [7:0]    sync1, sync2, cand, committed;
  logic [CW-1:0] cnt;
  logic          commit_evt;
  logic          conv_evt, conv_ok;
  logic [6:0]    conv_val;
  logic          offer;

  state_t        state_q, state_d;
  logic [6:0]    value_q, value_d, pend_q, pend_d;
  logic          valid_q, overrun_d;

  logic [3:0]    c_tens, c_ones;
  assign c_tens = committed[7:4];
  assign c_ones = committed[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 8'h00;
      sync2      <= 8'h00;
      cand       <= 8'hFF;
      cnt        <= '0;
      committed  <= 8'hFF;
      commit_evt <= 1'b0;
      conv_evt   <= 1'b0;
      conv_ok    <= 1'b0;
      conv_val   <= 7'd0;
    end else begin
      sync1 <= {tens_pin, ones_pin};
      sync2 <= sync1;
      if (sync2 != cand) begin
        cand <= sync2;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      // A reading equal to the last committed one is never recommitted
      if (cnt == CNT_MAX && cand != committed) begin
        committed  <= cand;
        commit_evt <= 1'b1;
      end else begin
        commit_evt <= 1'b0;
      end
      conv_evt <= commit_evt;
      conv_ok  <= (c_tens <= 4'd9) && (c_ones <= 4'd9);
      conv_val <= {c_tens, 3'b000} + {2'b00, c_tens, 1'b0} + {3'b000, c_ones};
    end
  end

  assign offer = conv_evt && conv_ok;

  always_comb begin
    state_d   = state_q;
    value_d   = value_q;
    pend_d    = pend_q;
    overrun_d = 1'b0;
    case (state_q)
      EMPTY: begin
        if (offer) begin
          value_d = conv_val;
          state_d = FULL;
        end
      end
      FULL: begin
        if (offer) begin
          if (bus.ready) begin
            value_d = conv_val;
          end else begin
            pend_d  = conv_val;
            state_d = FULL_PEND;
          end
        end else if (bus.ready) begin
          state_d = EMPTY;
        end
      end
      FULL_PEND: begin
        if (bus.ready) begin
          value_d = pend_q;
          if (offer) pend_d = conv_val;
          else       state_d = FULL;
        end else if (offer) begin
          pend_d    = conv_val;
          overrun_d = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      value_q   <= 7'd0;
      pend_q    <= 7'd0;
      valid_q   <= 1'b0;
      overrun   <= 1'b0;
      bcd_error <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      pend_q  <= pend_d;
      valid_q <= (state_d != EMPTY);
      overrun <= overrun_d;
      if (conv_evt) bcd_error <= !conv_ok;
    end
  end

  assign bus.value = value_q;
  assign bus.valid = valid_q;

endmodule

// File: tb/tb_bcd_switch_reader.sv
// tb/tb_bcd_switch_reader.sv - scoreboard bench for bcd_switch_reader with directed switch patterns
module tb_bcd_switch_reader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ones_pin, tens_pin;
  logic       bcd_error, overrun;
  int         checks = 0;
  int         errors = 0;
  int         ovr_cnt = 0;
  int         ovr_base;
  int         exp_q[$];

  bcd_switch_reader_if bus ();

  bcd_switch_reader #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ones_pin  (ones_pin),
    .tens_pin  (tens_pin),
    .bcd_error (bcd_error),
    .overrun   (overrun),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pins(input logic [7:0] p);
    {tens_pin, ones_pin} = p;
  endtask

  // Transfers complete at the next rising edge; inputs are stable from #1 after an edge
  always @(negedge clk) begin
    if (rst_n && bus.valid && bus.ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_transfer: got %0d expected none", bus.value);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(bus.value) != e) begin
          errors++;
          $display("FAIL transfer_value: got %0d expected %0d", bus.value, e);
        end
      end
    end
    if (rst_n && overrun) ovr_cnt++;
  end

  initial begin
    bus.ready = 1'b0;
    pins(8'h42);
    tick(2);
    check("reset_valid", bus.valid, 0);
    check("reset_value", bus.value, 0);
    check("reset_bcd_error", bcd_error, 0);
    check("reset_overrun", overrun, 0);
    rst_n = 1'b1;

    // first reading latency
    tick(8);
    check("lat42_not_yet", bus.valid, 0);
    tick(1);
    check("lat42_valid", bus.valid, 1);
    check("lat42_value", bus.value, 42);
    check("lat42_err", bcd_error, 0);
    tick(5);
    check("hold42_valid", bus.valid, 1);
    check("hold42_value", bus.value, 42);
    exp_q.push_back(42);
    bus.ready = 1'b1;
    tick(1);
    bus.ready = 1'b0;
    check("drain42_valid", bus.valid, 0);

    // short transient back to the same reading
    pins(8'h43);
    tick(2);
    pins(8'h42);
    tick(20);
    check("transient_no_valid", bus.valid, 0);

    // bouncing contacts
    for (int i = 0; i < 5; i++) begin
      pins(8'h17); tick(2);
      pins(8'h18); tick(2);
    end
    pins(8'h17); tick(2);
    check("bounce_no_commit", bus.valid, 0);
    pins(8'h18);
    tick(8);
    check("bounce_not_yet", bus.valid, 0);
    tick(1);
    check("bounce_valid", bus.valid, 1);
    check("bounce_value", bus.value, 18);
    exp_q.push_back(18);
    bus.ready = 1'b1;
    tick(1);
    bus.ready = 1'b0;
    check("bounce_drain", bus.valid, 0);

    // pending overwrite
    pins(8'h05); tick(12);
    check("pend_v5_valid", bus.valid, 1);
    check("pend_v5_value", bus.value, 5);
    ovr_base = ovr_cnt;
    pins(8'h06); tick(12);
    check("pend_v6_value", bus.value, 5);
    check("pend_v6_no_ovr", ovr_cnt - ovr_base, 0);
    pins(8'h07); tick(12);
    check("pend_ovr_pulses", ovr_cnt - ovr_base, 1);
    check("pend_v7_value", bus.value, 5);
    exp_q.push_back(5);
    exp_q.push_back(7);
    bus.ready = 1'b1;
    tick(1);
    check("pend_second_valid", bus.valid, 1);
    check("pend_second_value", bus.value, 7);
    tick(1);
    check("pend_empty", bus.valid, 0);
    bus.ready = 1'b0;

    // invalid BCD then valid
    pins(8'h3A); tick(12);
    check("bad_err", bcd_error, 1);
    check("bad_valid", bus.valid, 0);
    check("bad_value", bus.value, 7);
    pins(8'h99); tick(12);
    check("good_err", bcd_error, 0);
    check("good_valid", bus.valid, 1);
    check("good_value", bus.value, 99);
    exp_q.push_back(99);
    bus.ready = 1'b1;
    tick(1);
    bus.ready = 1'b0;

    // reset mid-debounce with a reading held
    pins(8'h42); tick(12);
    check("pre_rst_valid", bus.valid, 1);
    check("pre_rst_value", bus.value, 42);
    pins(8'h55); tick(3);
    rst_n = 1'b0;
    #1;
    check("rst_valid", bus.valid, 0);
    check("rst_value", bus.value, 0);
    check("rst_err", bcd_error, 0);
    check("rst_overrun", overrun, 0);
    pins(8'h42);
    tick(2);
    rst_n = 1'b1;
    tick(8);
    check("relat_not_yet", bus.valid, 0);
    tick(1);
    check("relat_valid", bus.valid, 1);
    check("relat_value", bus.value, 42);
    exp_q.push_back(42);
    bus.ready = 1'b1;
    tick(1);
    bus.ready = 1'b0;

    // offer arriving on the same edge as a transfer
    pins(8'h00); tick(12);
    check("sim_v0_valid", bus.valid, 1);
    check("sim_v0_value", bus.value, 0);
    pins(8'h01);
    tick(8);
    bus.ready = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(1);
    tick(1);
    check("sim_valid_kept", bus.valid, 1);
    check("sim_value_1", bus.value, 1);
    tick(1);
    check("sim_drained", bus.valid, 0);
    bus.ready = 1'b0;
    tick(2);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
